// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the keyboard event decoder:
// code classes, key/encoder counts and code validation.
package kbd_evt_pkg;

    typedef enum logic [1:0] {
        CLS_INV     = 2'b00,
        CLS_PRESS   = 2'b01,
        CLS_RELEASE = 2'b10,
        CLS_ENC     = 2'b11
    } evt_cls_e;

    localparam int NUM_KEYS      = 33;
    localparam int NUM_ENC       = 4;
    localparam int ENC_MARKER    = 0;
    localparam int ENC_CURVE     = 1;
    localparam int ENC_DURATION  = 2;
    localparam int ENC_AMPLITUDE = 3;

    localparam int KEY_IDX_MAX = NUM_KEYS - 1;
    localparam int ENC_IDX_MAX = 2 * NUM_ENC - 1;

    function automatic logic code_ok(logic [7:0] code);
        logic [5:0] idx;
        logic       ok;
        idx = code[5:0];
        ok  = 1'b0;
        unique case (evt_cls_e'(code[7:6]))
            CLS_PRESS:   ok = (idx <= 6'(KEY_IDX_MAX));
            CLS_RELEASE: ok = (idx <= 6'(KEY_IDX_MAX));
            CLS_ENC:     ok = (idx <= 6'(ENC_IDX_MAX));
            CLS_INV:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Event-in / state-out bundle between the keyboard reader,
// the decoder and the host bridge.
interface key_event_decoder_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int POS_W      = 8
);
    import kbd_evt_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                     evt_valid;
    logic [7:0]               evt_code;
    logic [NUM_ENC-1:0]       enc_clr;
    logic                     fifo_rd;
    logic                     overflow_clr;

    logic [NUM_KEYS-1:0]      key_state;
    logic [NUM_ENC*POS_W-1:0] enc_pos;
    logic [7:0]               fifo_data;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic                     overflow;
    logic [7:0]               bad_code_cnt;
    logic                     irq;

    modport master (
        output evt_valid, evt_code, enc_clr, fifo_rd, overflow_clr,
        input  key_state, enc_pos, fifo_data, fifo_empty,
        input  fifo_count, overflow, bad_code_cnt, irq
    );

    modport slave (
        input  evt_valid, evt_code, enc_clr, fifo_rd, overflow_clr,
        output key_state, enc_pos, fifo_data, fifo_empty,
        output fifo_count, overflow, bad_code_cnt, irq
    );

endinterface

// File: rtl/key_event_decoder_fifo.sv
// Event log: synchronous FIFO with a registered show-ahead head
// and a drop indication for pushes refused while full.
module key_evt_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic             drop_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign do_pop  = rd_i && (cnt_q != '0);
    // A full log still accepts a push when a pop frees the slot.
    assign do_push = wr_i && (!full || do_pop);
    assign drop_o  = wr_i && full && !rd_i;

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
        if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
        head_d = '0;
        if (cnt_d != '0) begin
            if (do_push && (rd_d == wr_q)) head_d = wdata_i;
            else                           head_d = mem[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    assign rdata_o = head_q;
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/key_event_decoder.sv
// Decodes keyboard event codes into a key bitmap, four saturating
// encoder positions and an event log for the host bridge.
module key_event_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int POS_W      = 8
) (
    input logic          clk,
    input logic          rst,
    key_event_decoder_if.slave bus
);
    import kbd_evt_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    logic [NUM_KEYS-1:0] key_q, key_d;
    logic [POS_W-1:0]    enc_q [NUM_ENC];
    logic [POS_W-1:0]    enc_d [NUM_ENC];
    logic                ovf_q, ovf_d;
    logic [7:0]          bad_q, bad_d;

    evt_cls_e   cls;
    logic [5:0] idx;
    logic       ok;
    logic       push;
    logic       fifo_drop;
    logic       fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0] fifo_data;

    assign cls  = evt_cls_e'(bus.evt_code[7:6]);
    assign idx  = bus.evt_code[5:0];
    assign ok   = code_ok(bus.evt_code);
    assign push = bus.evt_valid && ok;

    always_comb begin
        key_d = key_q;
        bad_d = bad_q;
        for (int k = 0; k < NUM_ENC; k++) begin
            enc_d[k] = enc_q[k];
        end
        if (bus.evt_valid && !ok && (bad_q != 8'hFF)) begin
            bad_d = bad_q + 8'd1;
        end
        if (push) begin
            unique case (cls)
                CLS_PRESS:   key_d[idx] = 1'b1;
                CLS_RELEASE: key_d[idx] = 1'b0;
                CLS_ENC: begin
                    for (int k = 0; k < NUM_ENC; k++) begin
                        if (idx[2:1] == 2'(k)) begin
                            if (idx[0] && (enc_q[k] != POS_MAX))
                                enc_d[k] = enc_q[k] + POS_W'(1);
                            else if (!idx[0] && (enc_q[k] != POS_MIN))
                                enc_d[k] = enc_q[k] - POS_W'(1);
                        end
                    end
                end
                CLS_INV: ;
            endcase
        end
        for (int k = 0; k < NUM_ENC; k++) begin
            if (bus.enc_clr[k]) enc_d[k] = '0;
        end
        ovf_d = ovf_q;
        if (bus.overflow_clr) ovf_d = 1'b0;
        if (fifo_drop)        ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
            ovf_q <= 1'b0;
            bad_q <= '0;
            for (int k = 0; k < NUM_ENC; k++) enc_q[k] <= '0;
        end else begin
            key_q <= key_d;
            ovf_q <= ovf_d;
            bad_q <= bad_d;
            for (int k = 0; k < NUM_ENC; k++) enc_q[k] <= enc_d[k];
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_log (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (push),
        .wdata_i (bus.evt_code),
        .rd_i    (bus.fifo_rd),
        .rdata_o (fifo_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    for (genvar k = 0; k < NUM_ENC; k++) begin : g_pos
        assign bus.enc_pos[k*POS_W +: POS_W] = enc_q[k];
    end

    assign bus.key_state    = key_q;
    assign bus.fifo_data    = fifo_data;
    assign bus.fifo_empty   = fifo_empty;
    assign bus.fifo_count   = fifo_count;
    assign bus.overflow     = ovf_q;
    assign bus.bad_code_cnt = bad_q;
    assign bus.irq          = ~fifo_empty;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: vector table plus
// hand sequences for saturation, overflow and reset corners.
module tb_key_event_decoder;
    import kbd_evt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    key_event_decoder_if #(.FIFO_DEPTH(8), .POS_W(8)) bus ();

    key_event_decoder #(.FIFO_DEPTH(8), .POS_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [7:0]  code;
        logic        rd;
        logic [32:0] key;
        logic [3:0]  cnt;
        logic [7:0]  data;
        logic [7:0]  bad;
    } vec_t;

    vec_t tv [15];

    function automatic vec_t mk(logic v, logic [7:0] code, logic rd,
                                logic [32:0] key, logic [3:0] cnt,
                                logic [7:0] data, logic [7:0] bad);
        vec_t r;
        r.v = v; r.code = code; r.rd = rd; r.key = key;
        r.cnt = cnt; r.data = data; r.bad = bad;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(logic v, logic [7:0] code, logic [3:0] clr,
                       logic rd, logic oclr);
        bus.evt_valid    = v;
        bus.evt_code     = code;
        bus.enc_clr      = clr;
        bus.fifo_rd      = rd;
        bus.overflow_clr = oclr;
        @(posedge clk);
        #1;
        bus.evt_valid    = 1'b0;
        bus.evt_code     = 8'h00;
        bus.enc_clr      = 4'h0;
        bus.fifo_rd      = 1'b0;
        bus.overflow_clr = 1'b0;
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, ".key"}, 64'(bus.key_state), 64'h0);
        chk({tag, ".enc"}, 64'(bus.enc_pos), 64'h0);
        chk({tag, ".data"}, 64'(bus.fifo_data), 64'h0);
        chk({tag, ".empty"}, 64'(bus.fifo_empty), 64'h1);
        chk({tag, ".cnt"}, 64'(bus.fifo_count), 64'h0);
        chk({tag, ".ovf"}, 64'(bus.overflow), 64'h0);
        chk({tag, ".bad"}, 64'(bus.bad_code_cnt), 64'h0);
        chk({tag, ".irq"}, 64'(bus.irq), 64'h0);
    endtask

    initial begin
        tv[0]  = mk(1, 8'h45, 0, 33'h20,          1, 8'h45, 0);
        tv[1]  = mk(1, 8'h85, 0, 33'h0,           2, 8'h45, 0);
        tv[2]  = mk(1, 8'h00, 0, 33'h0,           2, 8'h45, 1);
        tv[3]  = mk(1, 8'h61, 0, 33'h0,           2, 8'h45, 2);
        tv[4]  = mk(1, 8'hC8, 0, 33'h0,           2, 8'h45, 3);
        tv[5]  = mk(0, 8'h00, 1, 33'h0,           1, 8'h85, 3);
        tv[6]  = mk(0, 8'h00, 1, 33'h0,           0, 8'h00, 3);
        tv[7]  = mk(0, 8'h00, 1, 33'h0,           0, 8'h00, 3);
        tv[8]  = mk(1, 8'h60, 0, 33'h1_0000_0000, 1, 8'h60, 3);
        tv[9]  = mk(1, 8'h60, 0, 33'h1_0000_0000, 2, 8'h60, 3);
        tv[10] = mk(1, 8'hE0, 0, 33'h1_0000_0000, 2, 8'h60, 4);
        tv[11] = mk(1, 8'hA0, 0, 33'h0,           3, 8'h60, 4);
        tv[12] = mk(0, 8'h00, 1, 33'h0,           2, 8'h60, 4);
        tv[13] = mk(0, 8'h00, 1, 33'h0,           1, 8'hA0, 4);
        tv[14] = mk(0, 8'h00, 1, 33'h0,           0, 8'h00, 4);

        rst = 1'b1;
        cyc(0, 8'h00, 4'h0, 0, 0);
        cyc(0, 8'h00, 4'h0, 0, 0);
        rst = 1'b0;
        chk_reset_state("rst0");

        for (int i = 0; i < 15; i++) begin
            cyc(tv[i].v, tv[i].code, 4'h0, tv[i].rd, 1'b0);
            chk($sformatf("tv%0d.key", i), 64'(bus.key_state), 64'(tv[i].key));
            chk($sformatf("tv%0d.cnt", i), 64'(bus.fifo_count), 64'(tv[i].cnt));
            chk($sformatf("tv%0d.data", i), 64'(bus.fifo_data), 64'(tv[i].data));
            chk($sformatf("tv%0d.bad", i), 64'(bus.bad_code_cnt), 64'(tv[i].bad));
            chk($sformatf("tv%0d.irq", i), 64'(bus.irq), 64'(tv[i].cnt != 0));
        end

        for (int i = 0; i < 300; i++) cyc(1, 8'h00, 4'h0, 0, 0);
        chk("bad_sat", 64'(bus.bad_code_cnt), 64'hFF);
        chk("bad_empty", 64'(bus.fifo_empty), 64'h1);

        for (int i = 0; i < 130; i++) cyc(1, 8'hC7, 4'h0, 0, 0);
        chk("enc3_max", 64'(bus.enc_pos), 64'h7F00_0000);
        cyc(1, 8'hC6, 4'h0, 0, 0);
        chk("enc3_dec", 64'(bus.enc_pos), 64'h7E00_0000);
        for (int i = 0; i < 130; i++) cyc(1, 8'hC0, 4'h0, 0, 0);
        chk("enc0_min", 64'(bus.enc_pos), 64'h7E00_0080);
        chk("enc_ovf", 64'(bus.overflow), 64'h1);
        chk("enc_cnt", 64'(bus.fifo_count), 64'h8);

        rst = 1'b1;
        cyc(0, 8'h00, 4'h0, 0, 0);
        rst = 1'b0;
        chk_reset_state("rst1");

        for (int i = 1; i <= 9; i++) cyc(1, 8'h40 + 8'(i), 4'h0, 0, 0);
        chk("t3.cnt", 64'(bus.fifo_count), 64'h8);
        chk("t3.ovf", 64'(bus.overflow), 64'h1);
        chk("t3.key", 64'(bus.key_state), 64'h3FE);
        chk("t3.data", 64'(bus.fifo_data), 64'h41);
        cyc(0, 8'h00, 4'h0, 1, 1);
        chk("t3.pop_cnt", 64'(bus.fifo_count), 64'h7);
        chk("t3.pop_ovf", 64'(bus.overflow), 64'h0);
        chk("t3.pop_data", 64'(bus.fifo_data), 64'h42);
        cyc(1, 8'h4A, 4'h0, 0, 0);
        cyc(1, 8'h4B, 4'h0, 0, 1);
        chk("ovf_setwins", 64'(bus.overflow), 64'h1);
        chk("ovf_cnt", 64'(bus.fifo_count), 64'h8);
        chk("ovf_key", 64'(bus.key_state), 64'hFFE);

        cyc(1, 8'h41, 4'h0, 1, 0);
        chk("t5.full_cnt", 64'(bus.fifo_count), 64'h8);
        chk("t5.full_head", 64'(bus.fifo_data), 64'h43);
        for (int i = 0; i < 7; i++) cyc(0, 8'h00, 4'h0, 1, 0);
        chk("t5.tail_cnt", 64'(bus.fifo_count), 64'h1);
        chk("t5.tail", 64'(bus.fifo_data), 64'h41);
        cyc(0, 8'h00, 4'h0, 1, 0);
        chk("t5.drain", 64'(bus.fifo_empty), 64'h1);
        cyc(1, 8'h4C, 4'h0, 1, 0);
        chk("t5.empty_cnt", 64'(bus.fifo_count), 64'h1);
        chk("t5.empty_data", 64'(bus.fifo_data), 64'h4C);

        rst = 1'b1;
        cyc(0, 8'h00, 4'h0, 0, 0);
        rst = 1'b0;
        cyc(1, 8'hC3, 4'h0, 0, 0);
        chk("t6.step", 64'(bus.enc_pos), 64'h0000_0100);
        cyc(1, 8'hC3, 4'h2, 0, 0);
        chk("t6.clrwins", 64'(bus.enc_pos), 64'h0);
        cyc(1, 8'hC3, 4'h0, 0, 0);
        cyc(1, 8'hC7, 4'h2, 0, 0);
        chk("t6.clr_other", 64'(bus.enc_pos), 64'h0100_0000);
        cyc(1, 8'h43, 4'h0, 0, 0);
        cyc(1, 8'h00, 4'h0, 0, 0);
        chk("t6.pre_key", 64'(bus.key_state), 64'h8);
        rst = 1'b1;
        cyc(1, 8'hC3, 4'h0, 0, 0);
        rst = 1'b0;
        chk_reset_state("rst2");
        cyc(1, 8'h44, 4'h0, 0, 0);
        chk("post_rst_key", 64'(bus.key_state), 64'h10);
        chk("post_rst_data", 64'(bus.fifo_data), 64'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
